// File: rtl/l0_skew.sv
// l0_skew: per-row input FIFOs with a diagonal (skewed) read wavefront.
// Every lane is written with the same vector. A read launches a wave:
// lane r pops r cycles after lane 0 and registers its head entry and the
// wave's instruction onto its out/inst_out fields.
// Requires row >= 2 and depth >= 2 (power of two).
module l0_skew #(
    parameter int row   = 8,
    parameter int bw    = 4,
    parameter int depth = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [row*bw-1:0]   in,
    input  logic                wr,
    input  logic                rd,
    input  logic [1:0]          inst_in,
    output logic [row*bw-1:0]   out,
    output logic [row*2-1:0]    inst_out,
    output logic                o_full,
    output logic                o_empty
);

    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;

    // All lanes are written together, so one write pointer serves every lane.
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q [row];
    logic [PW-1:0] rptr_d [row];
    logic [bw-1:0] mem_q  [row][depth];

    // Skew line: stage s carries the wave that lane s+1 pops this cycle.
    logic [row-2:0] skv_q, skv_d;
    logic [1:0]     ski_q [row-1];
    logic [1:0]     ski_d [row-1];

    logic [row-1:0] pend_v;
    logic [1:0]     pend_i [row];
    logic [row-1:0] lane_full, lane_empty, pop;
    logic           wr_go;

    logic [bw-1:0]  out_q [row];
    logic [bw-1:0]  out_d [row];
    logic [1:0]     io_q  [row];
    logic [1:0]     io_d  [row];

    // Per-lane occupancy flags from the current pointers.
    always_comb begin
        lane_full  = '0;
        lane_empty = '0;
        for (int r = 0; r < row; r++) begin
            lane_empty[r] = (wptr_q == rptr_q[r]);
            lane_full[r]  = (wptr_q[AW-1:0] == rptr_q[r][AW-1:0]) &&
                            (wptr_q[AW] != rptr_q[r][AW]);
        end
        o_full  = |lane_full;
        o_empty = &lane_empty;
        wr_go   = wr && !o_full && !reset;
    end

    // Pending pop per lane: lane 0 takes rd directly, others take the skew line.
    always_comb begin
        pend_v    = '0;
        pend_i[0] = inst_in;
        pend_v[0] = rd && !reset;
        for (int r = 1; r < row; r++) begin
            pend_v[r] = skv_q[r-1];
            pend_i[r] = ski_q[r-1];
        end
        // A pop on an empty lane is a bubble; a same-cycle write does not count.
        pop = pend_v & ~lane_empty;
    end

    // Next-state for pointers, skew line and registered lane outputs.
    always_comb begin
        wptr_d = wptr_q + PW'(wr_go);
        skv_d  = pend_v[row-2:0];
        for (int s = 0; s < row - 1; s++) begin
            ski_d[s] = pend_i[s];
        end
        for (int r = 0; r < row; r++) begin
            rptr_d[r] = rptr_q[r] + PW'(pop[r]);
            out_d[r]  = pop[r] ? mem_q[r][rptr_q[r][AW-1:0]] : '0;
            io_d[r]   = pop[r] ? pend_i[r] : 2'b00;
        end
    end

    // State registers with synchronous reset; reset also cancels in-flight waves.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            skv_q  <= '0;
            for (int s = 0; s < row - 1; s++) begin
                ski_q[s] <= 2'b00;
            end
            for (int r = 0; r < row; r++) begin
                rptr_q[r] <= '0;
                out_q[r]  <= '0;
                io_q[r]   <= 2'b00;
            end
        end else begin
            wptr_q <= wptr_d;
            skv_q  <= skv_d;
            for (int s = 0; s < row - 1; s++) begin
                ski_q[s] <= ski_d[s];
            end
            for (int r = 0; r < row; r++) begin
                rptr_q[r] <= rptr_d[r];
                out_q[r]  <= out_d[r];
                io_q[r]   <= io_d[r];
            end
        end
    end

    // Storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_go) begin
            for (int r = 0; r < row; r++) begin
                mem_q[r][wptr_q[AW-1:0]] <= in[r*bw +: bw];
            end
        end
    end

    // Pack lane registers onto the flat output buses.
    always_comb begin
        out      = '0;
        inst_out = '0;
        for (int r = 0; r < row; r++) begin
            out[r*bw +: bw]   = out_q[r];
            inst_out[r*2 +: 2] = io_q[r];
        end
    end

endmodule
